// File: rtl/dest_track_pkg.sv
// Shared encodings and defaults for the destination tracking pipeline.
// Optional explicit-address select is enabled by DEST_TRACK_EXT_ADDR_EN.
package dest_track_pkg;

  localparam int ADDR_W_DEF    = 5;
  localparam int STAGES_DEF    = 3;
  localparam int TNEW_W_DEF    = 2;
  localparam int LINK_ADDR_DEF = 31;

  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [1:0] {
    SEL_RT   = 2'd0,
    SEL_RD   = 2'd1,
    SEL_LINK = 2'd2,
    SEL_EXT  = 2'd3
  } sel_mode_e;

endpackage

// File: rtl/dest_match_prio.sv
// Per-operand producer lookup: youngest-first forward select
// plus a pending flag when a producer is not ready in time.
module dest_match_prio
  import dest_track_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int TNEW_W = TNEW_W_DEF
) (
  input  logic [STAGES*ADDR_W-1:0] i_addr,
  input  logic [STAGES*TNEW_W-1:0] i_tnew,
  input  logic [ADDR_W-1:0]        i_use,
  input  logic [TNEW_W-1:0]        i_tuse,
  output logic [STAGES-1:0]        o_fwd,
  output logic                     o_pending
);

  logic [STAGES-1:0] w_hit;
  logic              w_seen;

  for (genvar g = 0; g < STAGES; g++) begin : g_hit
    assign w_hit[g] =
      (i_addr[g*ADDR_W +: ADDR_W] == i_use) &&
      (i_use != ADDR_W'(ZERO_REG));
  end

  // Youngest hit owns the operand; a not-ready one blocks older stages.
  always_comb begin
    o_fwd     = '0;
    o_pending = 1'b0;
    w_seen    = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (w_hit[i]) begin
        if (i_tnew[i*TNEW_W +: TNEW_W] > i_tuse)
          o_pending = 1'b1;
        if (!w_seen &&
            i_tnew[i*TNEW_W +: TNEW_W] == '0)
          o_fwd[i] = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dest_track_pipe.sv
// Destination select and {addr,tnew} tracking for the hazard unit.
// DEST_TRACK_EXT_ADDR_EN: sel_mode 3 selects ext_addr instead of 0.
module dest_track_pipe
  import dest_track_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int STAGES    = STAGES_DEF,
  parameter int TNEW_W    = TNEW_W_DEF,
  parameter int LINK_ADDR = LINK_ADDR_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        instr_rt,
  input  logic [ADDR_W-1:0]        instr_rd,
  input  logic [1:0]               sel_mode,
  input  logic [ADDR_W-1:0]        ext_addr,
  input  logic                     reg_we,
  input  logic [TNEW_W-1:0]        tnew_in,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        rs_use,
  input  logic [ADDR_W-1:0]        rt_use,
  input  logic [TNEW_W-1:0]        tuse_rs,
  input  logic [TNEW_W-1:0]        tuse_rt,
  output logic [ADDR_W-1:0]        dest_now,
  output logic [STAGES*ADDR_W-1:0] dest_q,
  output logic [STAGES*TNEW_W-1:0] tnew_q,
  output logic                     stall,
  output logic [STAGES-1:0]        fwd_rs_sel,
  output logic [STAGES-1:0]        fwd_rt_sel
);

`ifdef DEST_TRACK_EXT_ADDR_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  logic [STAGES-1:0][ADDR_W-1:0] r_addr;
  logic [STAGES-1:0][TNEW_W-1:0] r_tnew;

  logic [ADDR_W-1:0] w_sel;
  logic              w_pend_rs;
  logic              w_pend_rt;
  logic              w_bubble;

  always_comb begin
    w_sel = '0;
    unique case (sel_mode_e'(sel_mode))
      SEL_RT:   w_sel = instr_rt;
      SEL_RD:   w_sel = instr_rd;
      SEL_LINK: w_sel = ADDR_W'(LINK_ADDR);
      SEL_EXT:  w_sel = ext_addr & {ADDR_W{EXT_EN}};
      default:  w_sel = '0;
    endcase
  end

  assign dest_now = reg_we ? w_sel : '0;
  assign w_bubble = stall | flush;

  // Older stages advance unconditionally; only E takes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_tnew <= '0;
    end else begin
      if (w_bubble) begin
        r_addr[0] <= '0;
        r_tnew[0] <= '0;
      end else begin
        r_addr[0] <= dest_now;
        r_tnew[0] <= tnew_in;
      end
      for (int i = 1; i < STAGES; i++) begin
        r_addr[i] <= r_addr[i-1];
        r_tnew[i] <= (r_tnew[i-1] == '0) ? '0 :
                     r_tnew[i-1] - TNEW_W'(1);
      end
    end
  end

  assign dest_q = r_addr;
  assign tnew_q = r_tnew;

  dest_match_prio #(
    .ADDR_W (ADDR_W),
    .STAGES (STAGES),
    .TNEW_W (TNEW_W)
  ) u_rs (
    .i_addr    (dest_q),
    .i_tnew    (tnew_q),
    .i_use     (rs_use),
    .i_tuse    (tuse_rs),
    .o_fwd     (fwd_rs_sel),
    .o_pending (w_pend_rs)
  );

  dest_match_prio #(
    .ADDR_W (ADDR_W),
    .STAGES (STAGES),
    .TNEW_W (TNEW_W)
  ) u_rt (
    .i_addr    (dest_q),
    .i_tnew    (tnew_q),
    .i_use     (rt_use),
    .i_tuse    (tuse_rt),
    .o_fwd     (fwd_rt_sel),
    .o_pending (w_pend_rt)
  );

  assign stall = w_pend_rs | w_pend_rt;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Directed checks for dest_track_pipe with default parameters.
// Honours DEST_TRACK_EXT_ADDR_EN for the mode-3 expectation.
module tb_dest_track_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  instr_rt, instr_rd, ext_addr;
  logic [1:0]  sel_mode;
  logic        reg_we;
  logic [1:0]  tnew_in;
  logic        flush;
  logic [4:0]  rs_use, rt_use;
  logic [1:0]  tuse_rs, tuse_rt;
  logic [4:0]  dest_now;
  logic [14:0] dest_q;
  logic [5:0]  tnew_q;
  logic        stall;
  logic [2:0]  fwd_rs_sel, fwd_rt_sel;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dest_track_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .instr_rt   (instr_rt),
    .instr_rd   (instr_rd),
    .sel_mode   (sel_mode),
    .ext_addr   (ext_addr),
    .reg_we     (reg_we),
    .tnew_in    (tnew_in),
    .flush      (flush),
    .rs_use     (rs_use),
    .rt_use     (rt_use),
    .tuse_rs    (tuse_rs),
    .tuse_rt    (tuse_rt),
    .dest_now   (dest_now),
    .dest_q     (dest_q),
    .tnew_q     (tnew_q),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp_m3;

  initial begin
`ifdef DEST_TRACK_EXT_ADDR_EN
    exp_m3 = 5'd12;
`else
    exp_m3 = 5'd0;
`endif
    reset = 1; sel_mode = 2'd1; instr_rd = 5'd7;
    instr_rt = 0; ext_addr = 0; reg_we = 1;
    tnew_in = 2'd1; flush = 0;
    rs_use = 0; rt_use = 0; tuse_rs = 0; tuse_rt = 0;

    for (int c = 0; c < 2; c++) begin
      tick;
      check("rst_dest", dest_q, 0);
      check("rst_tnew", tnew_q, 0);
      check("rst_stall", stall, 0);
      check("rst_fwd", {fwd_rs_sel, fwd_rt_sel}, 0);
    end
    reset = 0;
    tick;
    check("first_load_dest", dest_q, 7);
    check("first_load_tnew", tnew_q, 1);

    // Select sweep
    instr_rt = 5'd5; instr_rd = 5'd9; ext_addr = 5'd12;
    for (int m = 0; m < 4; m++) begin
      sel_mode = 2'(m);
      #1;
      case (m)
        0: check("sel_rt", dest_now, 5);
        1: check("sel_rd", dest_now, 9);
        2: check("sel_link", dest_now, 31);
        default: check("sel_m3", dest_now, exp_m3);
      endcase
      reg_we = 0;
      #1;
      check("sel_we0", dest_now, 0);
      reg_we = 1;
    end

    reg_we = 0; tnew_in = 0;
    tick; tick; tick;
    check("drain_dest", dest_q, 0);
    check("drain_tnew", tnew_q, 0);

    // Load-use: producer 8 with tnew 2, consumer needs rs now
    sel_mode = 2'd0; instr_rt = 5'd8; reg_we = 1; tnew_in = 2;
    tick;
    sel_mode = 2'd1; instr_rd = 5'd10; tnew_in = 1;
    rs_use = 5'd8; tuse_rs = 0;
    #1;
    check("lu_stall0", stall, 1);
    check("lu_tnew_e", tnew_q, 2);
    check("lu_fwd0", fwd_rs_sel, 0);
    tick;
    check("lu_stall1", stall, 1);
    check("lu_dest1", dest_q, 15'(8 << 5));
    check("lu_tnew_m", tnew_q, 6'(1 << 2));
    tick;
    check("lu_stall2", stall, 0);
    check("lu_fwd_w", fwd_rs_sel, 3'b100);
    check("lu_dest2", dest_q, 15'(8 << 10));
    tick;
    check("lu_load_dest", dest_q, 10);
    check("lu_load_tnew", tnew_q, 1);

    // Reset mid-flight drops everything
    rs_use = 0; reset = 1;
    tick;
    check("midrst_dest", dest_q, 0);
    check("midrst_tnew", tnew_q, 0);
    reset = 0;

    // ALU back-to-back on rt
    sel_mode = 2'd1; instr_rd = 5'd4; tnew_in = 1; reg_we = 1;
    tick;
    reg_we = 0; tnew_in = 0; rt_use = 5'd4; tuse_rt = 1;
    #1;
    check("alu_stall", stall, 0);
    check("alu_fwd_e", fwd_rt_sel, 0);
    tick;
    check("alu_fwd_m", fwd_rt_sel, 3'b010);
    check("alu_stall2", stall, 0);

    // Priority: addr 6 in stages 0 and 2, addr 0 tnew 2 in stage 1
    rt_use = 0; tuse_rt = 0;
    sel_mode = 2'd0; instr_rt = 5'd6; reg_we = 1; tnew_in = 0;
    tick;
    reg_we = 0; tnew_in = 3;
    tick;
    reg_we = 1; tnew_in = 0;
    tick;
    check("prio_dest", dest_q, 15'(6 + (6 << 10)));
    check("prio_tnew", tnew_q, 6'(2 << 2));
    rs_use = 5'd6; tuse_rs = 0;
    #1;
    check("prio_fwd", fwd_rs_sel, 3'b001);
    check("prio_stall", stall, 0);
    rs_use = 5'd0;
    #1;
    check("zero_fwd", fwd_rs_sel, 0);
    check("zero_stall", stall, 0);

    // Flush + stall together: single bubble, saturation past W
    instr_rt = 5'd3; tnew_in = 3; reg_we = 1;
    tick;
    rs_use = 5'd3; tuse_rs = 0; flush = 1;
    sel_mode = 2'd1; instr_rd = 5'd11; tnew_in = 1;
    #1;
    check("fs_stall", stall, 1);
    tick;
    check("fs_dest", dest_q, 15'((3 << 5) + (6 << 10)));
    check("fs_tnew", tnew_q, 6'(2 << 2));
    flush = 0; rs_use = 0;
    #1;
    check("fs_nostall", stall, 0);
    tick;
    check("fs_after_dest", dest_q, 15'(11 + (3 << 10)));
    check("fs_after_tnew", tnew_q, 6'(1 + (1 << 4)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
